// File: rtl/playfield_settle_engine.sv
// Tetris playfield store: locks pieces into an occupancy/colour grid, clears full rows one per cycle,
// keeps score and serves collision queries and renderer reads. Define SCORE_TABLE_EN for 0/1/3/5/8 scoring.
module playfield_settle_engine #(
    parameter int unsigned COLS       = 10,
    parameter int unsigned ROWS       = 20,
    parameter int unsigned XW         = 4,
    parameter int unsigned YW         = 5,
    parameter int unsigned CW         = 3,
    parameter int unsigned SCORE_W    = 16,
    parameter int unsigned SPAWN_ROWS = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ce,
    input  logic               lock_req,
    output logic               lock_ready,
    input  logic [4*XW-1:0]    lock_x,
    input  logic [4*YW-1:0]    lock_y,
    input  logic [CW-1:0]      lock_color,
    output logic               lock_done,
    output logic [2:0]         lines,
    input  logic [4*XW-1:0]    q_x,
    input  logic [4*YW-1:0]    q_y,
    output logic               q_hit,
    input  logic [XW-1:0]      rd_x,
    input  logic [YW-1:0]      rd_y,
    output logic [CW-1:0]      rd_color,
    output logic [SCORE_W-1:0] score,
    output logic               game_over
);

    localparam logic [XW:0] ColsL  = (XW+1)'(COLS);
    localparam logic [YW:0] RowsL  = (YW+1)'(ROWS);
    localparam logic [YW:0] SpawnL = (YW+1)'(SPAWN_ROWS);

    typedef enum logic [2:0] {StIdle, StLock, StScan, StShift, StDone} state_e;

    state_e                              state_q;
    logic [ROWS-1:0][COLS-1:0]           occ_q, occ_lock, occ_shift;
    logic [ROWS-1:0][COLS-1:0][CW-1:0]   col_q, col_lock, col_shift;
    logic [4*XW-1:0]                     cap_x_q;
    logic [4*YW-1:0]                     cap_y_q;
    logic [CW-1:0]                       cap_color_q;
    logic [YW-1:0]                       row_q;
    logic [2:0]                          lines_q;
    logic                                lock_done_q;
    logic [SCORE_W-1:0]                  score_q, score_next;
    logic [SCORE_W+3:0]                  score_sum;
    logic [3:0]                          score_add;
    logic                                game_over_q;
    logic [CW-1:0]                       rd_color_q;
    logic                                row_full;
    logic                                spawn_hit;

    // Coordinates are unsigned, so a negative wrap from the mover lands out of range here.
    function automatic logic in_grid(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return ({1'b0, x} < ColsL) && ({1'b0, y} < RowsL);
    endfunction

    assign lock_ready = (state_q == StIdle) && !game_over_q;
    assign row_full   = &occ_q[row_q];
    assign lock_done  = lock_done_q;
    assign lines      = lines_q;
    assign score      = score_q;
    assign game_over  = game_over_q;
    assign rd_color   = rd_color_q;

    always_comb begin
        q_hit = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!in_grid(q_x[k*XW +: XW], q_y[k*YW +: YW])) begin
                q_hit = 1'b1;
            end else if (occ_q[q_y[k*YW +: YW]][q_x[k*XW +: XW]]) begin
                q_hit = 1'b1;
            end
        end
    end

    // Next grid images for the LOCK and SHIFT states.
    always_comb begin
        occ_shift = occ_q;
        col_shift = col_q;
        for (int r = 1; r < int'(ROWS); r++) begin
            if (YW'(r) <= row_q) begin
                occ_shift[r] = occ_q[r-1];
                col_shift[r] = col_q[r-1];
            end
        end
        occ_shift[0] = '0;
        col_shift[0] = '0;

        occ_lock  = occ_q;
        col_lock  = col_q;
        spawn_hit = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (in_grid(cap_x_q[k*XW +: XW], cap_y_q[k*YW +: YW])) begin
                occ_lock[cap_y_q[k*YW +: YW]][cap_x_q[k*XW +: XW]] = 1'b1;
                col_lock[cap_y_q[k*YW +: YW]][cap_x_q[k*XW +: XW]] = cap_color_q;
                if ({1'b0, cap_y_q[k*YW +: YW]} < SpawnL) spawn_hit = 1'b1;
            end
        end
    end

    always_comb begin
`ifdef SCORE_TABLE_EN
        case (lines_q)
            3'd1:    score_add = 4'd1;
            3'd2:    score_add = 4'd3;
            3'd3:    score_add = 4'd5;
            3'd4:    score_add = 4'd8;
            default: score_add = 4'd0;
        endcase
`else
        score_add = {1'b0, lines_q};
`endif
        score_sum  = (SCORE_W+4)'(score_q) + (SCORE_W+4)'(score_add);
        score_next = (|score_sum[SCORE_W+3:SCORE_W]) ? '1 : score_sum[SCORE_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            occ_q       <= '0;
            col_q       <= '0;
            cap_x_q     <= '0;
            cap_y_q     <= '0;
            cap_color_q <= '0;
            row_q       <= '0;
            lines_q     <= '0;
            lock_done_q <= 1'b0;
            score_q     <= '0;
            game_over_q <= 1'b0;
            rd_color_q  <= '0;
        end else begin
            // Renderer port runs regardless of ce.
            if (in_grid(rd_x, rd_y) && occ_q[rd_y][rd_x]) rd_color_q <= col_q[rd_y][rd_x];
            else rd_color_q <= '0;

            if (ce) begin
                lock_done_q <= 1'b0;
                case (state_q)
                    StIdle: begin
                        if (lock_req && lock_ready) begin
                            cap_x_q     <= lock_x;
                            cap_y_q     <= lock_y;
                            cap_color_q <= lock_color;
                            state_q     <= StLock;
                        end
                    end
                    StLock: begin
                        occ_q   <= occ_lock;
                        col_q   <= col_lock;
                        if (spawn_hit) game_over_q <= 1'b1;
                        row_q   <= YW'(ROWS - 1);
                        lines_q <= '0;
                        state_q <= StScan;
                    end
                    StScan: begin
                        if (row_full) begin
                            state_q <= StShift;
                        end else if (row_q == '0) begin
                            state_q     <= StDone;
                            lock_done_q <= 1'b1;
                        end else begin
                            row_q <= row_q - 1'b1;
                        end
                    end
                    StShift: begin
                        // Row pointer stays put so the row that dropped in is rescanned.
                        occ_q   <= occ_shift;
                        col_q   <= col_shift;
                        if (lines_q != 3'd4) lines_q <= lines_q + 3'd1;
                        state_q <= StScan;
                    end
                    StDone: begin
                        score_q <= score_next;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_playfield_settle_engine.sv
// Self-checking bench for playfield_settle_engine: directed tables plus randomized locks against a
// row-compaction reference model.
module tb_playfield_settle_engine;

    localparam int COLS = 10;
    localparam int ROWS = 20;
    localparam int XW   = 4;
    localparam int YW   = 5;
    localparam int CW   = 3;
    localparam int SW   = 5;
    localparam int SP   = 3;
    localparam int SMAX = (1 << SW) - 1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              ce = 1'b1;
    logic              lock_req = 1'b0;
    logic              lock_ready;
    logic [4*XW-1:0]   lock_x = '0;
    logic [4*YW-1:0]   lock_y = '0;
    logic [CW-1:0]     lock_color = '0;
    logic              lock_done;
    logic [2:0]        lines;
    logic [4*XW-1:0]   q_x = '0;
    logic [4*YW-1:0]   q_y = '0;
    logic              q_hit;
    logic [XW-1:0]     rd_x = '0;
    logic [YW-1:0]     rd_y = '0;
    logic [CW-1:0]     rd_color;
    logic [SW-1:0]     score;
    logic              game_over;

    playfield_settle_engine #(
        .COLS(COLS), .ROWS(ROWS), .XW(XW), .YW(YW), .CW(CW), .SCORE_W(SW), .SPAWN_ROWS(SP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .lock_req(lock_req), .lock_ready(lock_ready),
        .lock_x(lock_x), .lock_y(lock_y), .lock_color(lock_color), .lock_done(lock_done),
        .lines(lines), .q_x(q_x), .q_y(q_y), .q_hit(q_hit), .rd_x(rd_x), .rd_y(rd_y),
        .rd_color(rd_color), .score(score), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // Reference model state
    int m_occ [ROWS][COLS];
    int m_col [ROWS][COLS];
    int m_score, m_lines, m_cleared;
    bit m_go;
    int lx [4];
    int ly [4];
    int lc;

    typedef struct {
        logic [4*XW-1:0] qx;
        logic [4*YW-1:0] qy;
        logic            hit;
    } qvec_t;
    qvec_t qtab [8];

    task automatic check(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [4*XW-1:0] px(input int a, input int b, input int c, input int d);
        return {XW'(d), XW'(c), XW'(b), XW'(a)};
    endfunction

    function automatic logic [4*YW-1:0] py(input int a, input int b, input int c, input int d);
        return {YW'(d), YW'(c), YW'(b), YW'(a)};
    endfunction

    function automatic int points(input int n);
`ifdef SCORE_TABLE_EN
        int tbl [5] = '{0, 1, 3, 5, 8};
        return tbl[n];
`else
        return n;
`endif
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                m_occ[r][c] = 0;
                m_col[r][c] = 0;
            end
        m_score = 0;
        m_go    = 0;
    endfunction

    // Place the cells, then drop every full row at once and pack the rest to the bottom.
    function automatic void model_lock();
        int no [ROWS][COLS];
        int nc [ROWS][COLS];
        int dst;
        bit full;
        for (int k = 0; k < 4; k++) begin
            if (lx[k] < COLS && ly[k] < ROWS) begin
                m_occ[ly[k]][lx[k]] = 1;
                m_col[ly[k]][lx[k]] = lc;
                if (ly[k] < SP) m_go = 1;
            end
        end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                no[r][c] = 0;
                nc[r][c] = 0;
            end
        dst = ROWS - 1;
        m_cleared = 0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            full = 1;
            for (int c = 0; c < COLS; c++) if (m_occ[r][c] == 0) full = 0;
            if (full) m_cleared++;
            else begin
                for (int c = 0; c < COLS; c++) begin
                    no[dst][c] = m_occ[r][c];
                    nc[dst][c] = m_col[r][c];
                end
                dst--;
            end
        end
        m_occ = no;
        m_col = nc;
        m_lines = (m_cleared > 4) ? 4 : m_cleared;
        m_score = m_score + points(m_lines);
        if (m_score > SMAX) m_score = SMAX;
    endfunction

    task automatic drive_lock();
        for (int k = 0; k < 4; k++) begin
            lock_x[k*XW +: XW] = XW'(lx[k]);
            lock_y[k*YW +: YW] = YW'(ly[k]);
        end
        lock_color = CW'(lc);
    endtask

    task automatic start_lock(output bit ok);
        ok = 0;
        @(negedge clk);
        for (int i = 0; i < 50 && !lock_ready; i++) @(negedge clk);
        if (!lock_ready) begin
            check("lock_ready_wait", 0, 1);
            return;
        end
        drive_lock();
        ce = 1'b1;
        lock_req = 1'b1;
        @(negedge clk);
        lock_req = 1'b0;
        ok = 1;
    endtask

    task automatic do_lock(input bit noise);
        bit ok;
        int cnt, exp_cnt;
        start_lock(ok);
        if (!ok) return;
        model_lock();
        exp_cnt = 1 + ROWS + 2 * m_cleared;
        cnt = 0;
        ce = noise ? ($urandom_range(0, 3) != 0) : 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ce) cnt++;
            if (lock_done) break;
            ce = noise ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        check("lock_done_seen", int'(lock_done), 1);
        check("lock_latency", cnt, exp_cnt);
        check("lines", int'(lines), m_lines);
        ce = 1'b1;
        @(negedge clk);
        check("lock_done_pulse", int'(lock_done), 0);
        check("score", int'(score), m_score);
        check("game_over", int'(game_over), int'(m_go));
        check("lock_ready_after", int'(lock_ready), int'(!m_go));
    endtask

    task automatic check_grid(input string tag);
        int bad, exp;
        bad = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                rd_x = XW'(c);
                rd_y = YW'(r);
                q_x  = {4{XW'(c)}};
                q_y  = {4{YW'(r)}};
                #1;
                if (int'(q_hit) != m_occ[r][c]) bad++;
                @(negedge clk);
                exp = m_occ[r][c] ? m_col[r][c] : 0;
                if (int'(rd_color) != exp) bad++;
            end
        check(tag, bad, 0);
    endtask

    task automatic rand_query();
        int x, y;
        bit exp;
        exp = 0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            x = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
            y = ($urandom_range(0, 7) == 0) ? int'($urandom_range(20, 31)) : int'($urandom_range(0, 19));
            q_x[k*XW +: XW] = XW'(x);
            q_y[k*YW +: YW] = YW'(y);
            if (x >= COLS || y >= ROWS) exp = 1;
            else if (m_occ[y][x] != 0) exp = 1;
        end
        #1;
        check("q_hit_rand", int'(q_hit), int'(exp));
    endtask

    task automatic set_cells(input int x0, input int x1, input int x2, input int x3,
                             input int y0, input int y1, input int y2, input int y3, input int col);
        lx[0] = x0; lx[1] = x1; lx[2] = x2; lx[3] = x3;
        ly[0] = y0; ly[1] = y1; ly[2] = y2; ly[3] = y3;
        lc = col;
    endtask

    task automatic single_clear();
        set_cells(0, 1, 2, 3, 19, 19, 19, 19, 1); do_lock(0);
        set_cells(4, 5, 6, 7, 19, 19, 19, 19, 2); do_lock(0);
        set_cells(8, 9, 15, 15, 19, 19, 0, 0, 3); do_lock(0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        int bad;

        qtab[0] = '{px(5, 6, 7, 8),   py(10, 10, 10, 10), 1'b0};
        qtab[1] = '{px(10, 1, 2, 3),  py(10, 5, 5, 5),    1'b1};
        qtab[2] = '{px(5, 2, 6, 7),   py(5, 19, 5, 5),    1'b1};
        qtab[3] = '{px(5, 5, 5, 5),   py(20, 5, 5, 5),    1'b1};
        qtab[4] = '{px(4, 5, 6, 7),   py(19, 19, 19, 19), 1'b0};
        qtab[5] = '{px(15, 1, 1, 1),  py(0, 1, 1, 1),     1'b1};
        qtab[6] = '{px(0, 1, 2, 3),   py(18, 18, 18, 18), 1'b0};
        qtab[7] = '{px(3, 9, 9, 9),   py(19, 0, 1, 2),    1'b1};

        // Reset state
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_lock_ready", int'(lock_ready), 1);
        check("rst_lock_done", int'(lock_done), 0);
        check("rst_lines", int'(lines), 0);
        check("rst_score", int'(score), 0);
        check("rst_game_over", int'(game_over), 0);
        check("rst_rd_color", int'(rd_color), 0);
        reset_n = 1'b1;

        // Bottom-row piece, no clear
        set_cells(0, 1, 2, 3, 19, 19, 19, 19, 5);
        do_lock(0);
        check("t1_lines", int'(lines), 0);
        check("t1_score", int'(score), 0);
        rd_x = 2; rd_y = 19;
        @(negedge clk);
        check("t1_rd_color", int'(rd_color), 5);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            q_x = qtab[i].qx;
            q_y = qtab[i].qy;
            #1;
            check("q_hit_table", int'(q_hit), int'(qtab[i].hit));
        end

        // Single-row clear, with out-of-range cells dropped
        set_cells(4, 5, 15, 3, 19, 19, 19, 25, 2);
        do_lock(0);
        set_cells(6, 7, 8, 9, 19, 19, 19, 19, 3);
        do_lock(0);
        check("t2_lines", int'(lines), 1);
        check("t2_score", int'(score), 1);
        check_grid("t2_grid");

        // Four-row clear
        for (int c = 1; c < COLS; c++) begin
            set_cells(c, c, c, c, 16, 17, 18, 19, c % 8);
            do_lock(0);
        end
        set_cells(0, 0, 0, 0, 16, 17, 18, 19, 6);
        do_lock(0);
        check("t3_lines", int'(lines), 4);
        check("t3_score", int'(score), 1 + points(4));
        check_grid("t3_grid");

        // Score saturation
        while (m_score < SMAX - 2) single_clear();
        for (int c = 0; c < COLS; c += 2) begin
            set_cells(c, c + 1, c, c + 1, 18, 18, 19, 19, 4);
            do_lock(0);
        end
        check("t6_lines", int'(lines), 2);
        check("t6_score_sat", int'(score), SMAX);
        single_clear();
        check("t6_score_hold", int'(score), SMAX);

        // Randomized locks with ce gaps
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        for (int n = 0; n < 25; n++) begin
            for (int k = 0; k < 4; k++) begin
                lx[k] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
                ly[k] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 31)) : int'($urandom_range(14, 19));
            end
            lc = $urandom_range(0, 7);
            do_lock(1);
            check_grid("rand_grid");
            repeat (3) rand_query();
        end
        ce = 1'b0;
        check_grid("ce_off_grid");
        ce = 1'b1;

        // Reset in the middle of processing
        set_cells(0, 1, 2, 3, 19, 19, 19, 19, 7);
        start_lock(ok);
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_score", int'(score), 0);
        check("midrst_lock_ready", int'(lock_ready), 1);
        check("midrst_lock_done", int'(lock_done), 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        check_grid("midrst_grid");

        // Game over on a spawn-zone cell
        set_cells(4, 4, 4, 4, 1, 2, 3, 4, 1);
        do_lock(0);
        check("t4_game_over", int'(game_over), 1);
        check("t4_lock_ready", int'(lock_ready), 0);
        set_cells(0, 1, 2, 3, 19, 19, 19, 19, 2);
        drive_lock();
        lock_req = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (lock_ready || lock_done) bad++;
        end
        lock_req = 1'b0;
        check("t4_req_ignored", bad, 0);
        check_grid("t4_grid");
        #2 reset_n = 1'b0;
        #1;
        check("t4_rst_game_over", int'(game_over), 0);
        check("t4_rst_score", int'(score), 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("t4_rst_lock_ready", int'(lock_ready), 1);
        check_grid("t4_rst_grid");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
